// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types and helpers for the FIFO packet reader.
package fifo_pkt_reader_pkg;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t COLLECT = 1'b0;
    localparam state_t HOLD    = 1'b1;

    // Default geometry
    localparam int unsigned DATA_WIDTH_DFLT    = 64;
    localparam int unsigned BEATS_PER_PKT_DFLT = 2;
    localparam int unsigned CNT_WIDTH_DFLT     = 16;

    // Beat counter width: at least one bit even for single-beat packets
    function automatic int unsigned calc_beat_cnt_width(input int unsigned beats);
        return (beats > 1) ? int'($clog2(beats)) : 1;
    endfunction

    // Packet width for a given beat size and beat count
    function automatic int unsigned calc_pkt_width(input int unsigned dw, input int unsigned beats);
        return dw * beats;
    endfunction

    // Bit offset of beat k; beat 0 sits in the most significant word
    function automatic int unsigned beat_offset(input int unsigned k,
                                                input int unsigned beats,
                                                input int unsigned dw);
        return (beats - 1 - k) * dw;
    endfunction

endpackage

// File: rtl/fifo_pkt_reader.sv
// Pops fixed-size multi-beat packets from a fall-through FIFO and
// presents each assembled packet on a valid/ack handshake.
module fifo_pkt_reader
    import fifo_pkt_reader_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH_DFLT,
    parameter int unsigned beats_per_pkt = BEATS_PER_PKT_DFLT,
    parameter int unsigned cnt_width     = CNT_WIDTH_DFLT
) (
    input  logic                                sys_clock_i,
    input  logic                                sys_reset_n_i,
    input  logic                                fifo_empty_i,
    input  logic [data_width-1:0]               fifo_data_i,
    output logic                                fifo_read_o,
    input  logic                                flush_i,
    output logic [data_width*beats_per_pkt-1:0] pkt_data_o,
    output logic                                pkt_valid_o,
    input  logic                                pkt_ack_i,
    output logic [cnt_width-1:0]                pkt_count_o,
    output logic                                busy_o
);

    localparam int unsigned pkt_width      = calc_pkt_width(data_width, beats_per_pkt);
    localparam int unsigned beat_cnt_width = calc_beat_cnt_width(beats_per_pkt);
    localparam int unsigned off_width      = (pkt_width > 1) ? int'($clog2(pkt_width)) : 1;
    localparam int unsigned slot0_off      = beat_offset(0, beats_per_pkt, data_width);
    localparam logic [beat_cnt_width-1:0] last_beat = beat_cnt_width'(beats_per_pkt - 1);

    state_t                      state_q, state_d;
    logic [beat_cnt_width-1:0]   beat_cnt_q, beat_cnt_d;
    logic [pkt_width-1:0]        pkt_q, pkt_d;
    logic [cnt_width-1:0]        count_q, count_d;
    logic                        busy_q, busy_d;
    logic [off_width-1:0]        wr_off;
    logic                        pop_c;

    // Pop strobe: only when data is present, never during reset or flush
    always_comb begin
        pop_c = sys_reset_n_i && !fifo_empty_i && !flush_i &&
                ((state_q == COLLECT) || ((state_q == HOLD) && pkt_ack_i));
    end

    // Next-state, packet assembly and delivery counter
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pkt_d      = pkt_q;
        count_d    = count_q;
        wr_off     = off_width'(beat_offset(32'(beat_cnt_q), beats_per_pkt, data_width));

        case (state_q)
            COLLECT: begin
                if (flush_i) begin
                    beat_cnt_d = '0;
                end else if (pop_c) begin
                    pkt_d[wr_off +: data_width] = fifo_data_i;
                    if (beat_cnt_q == last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        beat_cnt_d = beat_cnt_q + beat_cnt_width'(1);
                    end
                end
            end
            HOLD: begin
                if (pkt_ack_i) begin
                    count_d = count_q + cnt_width'(1);
                    if (pop_c) begin
                        // Beat 0 of the next packet lands on the ack edge
                        pkt_d[slot0_off +: data_width] = fifo_data_i;
                        if (beats_per_pkt == 1) begin
                            state_d    = HOLD;
                            beat_cnt_d = '0;
                        end else begin
                            state_d    = COLLECT;
                            beat_cnt_d = beat_cnt_width'(1);
                        end
                    end else begin
                        state_d    = COLLECT;
                        beat_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d    = COLLECT;
                beat_cnt_d = '0;
            end
        endcase

        busy_d = (beat_cnt_d != '0) || (state_d == HOLD);
    end

    // State, packet, counter and busy registers
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
            pkt_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_q      <= pkt_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_read_o = pop_c;
    assign pkt_data_o  = pkt_q;
    assign pkt_valid_o = (state_q == HOLD);
    assign pkt_count_o = count_q;
    assign busy_o      = busy_q;

endmodule
